btb_flush_ctrl: RTL

- Owns the single write port of the 32-entry direct-mapped BTB.
- Arbitrates between EX-stage taken-branch/jump updates and a full-table invalidation sweep, requested on fence.i or context switch.
- While sweeping, forces fetch lookups to miss and back-pressures EX updates.
- Sits between the EX-stage resolve logic, the BTB storage and the fetch-stage hit path.

---
 rtl/btb_flush_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/btb_flush_ctrl.sv
// BTB write-port owner: EX updates vs. full-table invalidation sweep.
// Optional: `define BTB_UPD_DURING_FLUSH_EN lets updates to swept entries in during SWEEP.
module btb_flush_ctrl #(
   parameter  int BTB_ENTRIES = 32,
   parameter  int TAG_W       = 20,
   localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_req_i,
   output logic             flush_ack_o,
   output logic             busy_o,
   input  logic             upd_valid_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic [TAG_W-1:0] upd_tag_i,
   input  logic [31:0]      upd_target_i,
   output logic             upd_ready_o,
   output logic             btb_we_o,
   output logic [IDX_W-1:0] btb_widx_o,
   output logic             btb_wvalid_o,
   output logic [TAG_W-1:0] btb_wtag_o,
   output logic [31:0]      btb_wtarget_o,
   output logic             lookup_en_o
);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(BTB_ENTRIES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             pend_q, pend_d;
   logic             upd_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      pend_d        = pend_q;
      upd_ok        = 1'b0;
      flush_ack_o   = 1'b0;
      busy_o        = 1'b0;
      upd_ready_o   = 1'b0;
      lookup_en_o   = 1'b0;
      btb_we_o      = 1'b0;
      btb_widx_o    = '0;
      btb_wvalid_o  = 1'b0;
      btb_wtag_o    = '0;
      btb_wtarget_o = '0;
      if (!rst_i) begin
         unique case (state_q)
            IDLE: begin
               upd_ready_o = 1'b1;
               lookup_en_o = 1'b1;
               upd_ok      = upd_valid_i;
               // a request left pending by DONE is honoured here
               if (flush_req_i || pend_q) begin
                  state_d = SWEEP;
                  ptr_d   = '0;
                  pend_d  = 1'b0;
               end
            end
            SWEEP: begin
               busy_o = 1'b1;
               if (flush_req_i) pend_d = 1'b1;
`ifdef BTB_UPD_DURING_FLUSH_EN
               upd_ok      = upd_valid_i && (upd_idx_i < ptr_q);
               upd_ready_o = upd_ok;
`endif
               if (!upd_ok) begin
                  btb_we_o   = 1'b1;
                  btb_widx_o = ptr_q;
                  ptr_d      = ptr_q + 1'b1;
                  if (ptr_q == LAST) begin
                     state_d = DONE;
                     ptr_d   = '0;
                  end
               end
            end
            DONE: begin
               flush_ack_o = 1'b1;
               busy_o      = 1'b1;
               lookup_en_o = 1'b1;
               upd_ready_o = 1'b1;
               upd_ok      = upd_valid_i;
               pend_d      = flush_req_i;
               if (pend_q) begin
                  state_d = SWEEP;
                  ptr_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (upd_ok) begin
         btb_we_o      = 1'b1;
         btb_widx_o    = upd_idx_i;
         btb_wvalid_o  = 1'b1;
         btb_wtag_o    = upd_tag_i;
         btb_wtarget_o = upd_target_i;
      end
   end

endmodule
